// File: rtl/dist_com_desc_dispatch_pkg.sv
// Shared descriptor layout and FSM encoding for the distribution common FIFO
// consumer and its statistics counters.
package dist_com_desc_dispatch_pkg;

  localparam int DESC_W       = 24;
  localparam int DESC_CH_MSB  = 23;
  localparam int DESC_CH_LSB  = 22;
  localparam int DESC_FLG_MSB = 21;
  localparam int DESC_FLG_LSB = 16;
  localparam int DESC_LEN_MSB = 15;
  localparam int DESC_LEN_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD    = 2'd1,
    ST_CAP   = 2'd2,
    ST_OFFER = 2'd3
  } state_t;

  typedef struct packed {
    logic [DESC_CH_MSB-DESC_CH_LSB:0]   ch;
    logic [DESC_FLG_MSB-DESC_FLG_LSB:0] flags;
    logic [DESC_LEN_MSB-DESC_LEN_LSB:0] len;
  } desc_t;

  // A descriptor is deliverable when it names an existing channel and carries bytes.
  function automatic logic desc_ok(input desc_t d, input int num_ch);
    return (int'(d.ch) < num_ch) && (d.len != '0);
  endfunction

endpackage

// File: rtl/dist_sat_cnt.sv
// Saturating up-counter used for the dispatcher statistics.
module dist_sat_cnt #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)                      r_cnt <= '0;
    else if (i_inc && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/dist_com_desc_dispatch.sv
// Pops descriptors from the non-FWFT common FIFO, validates them and offers each
// to one channel over valid/ready, dropping bad or unaccepted descriptors.
module dist_com_desc_dispatch
  import dist_com_desc_dispatch_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DESC_W-1:0] i_fifo_dout,
  input  logic              i_fifo_empty,
  output logic              o_fifo_rd_en,
  output logic [NUM_CH-1:0] o_ch_valid,
  output logic [DESC_W-1:0] o_ch_desc,
  input  logic [NUM_CH-1:0] i_ch_ready,
  output logic [CNT_W-1:0]  o_desc_cnt,
  output logic [CNT_W-1:0]  o_drop_cnt,
  output logic              o_err_pulse
);

  localparam int TMO_W = 16;

  state_t            r_state, w_state_nxt;
  logic [TMO_W-1:0]  r_tmo;
  logic [NUM_CH-1:0] r_valid;
  desc_t             r_desc;
  logic              r_err;

  desc_t w_in;
  logic  w_ok, w_hs, w_tmo, w_drop, w_rd;

  assign w_in   = desc_t'(i_fifo_dout);
  assign w_ok   = desc_ok(w_in, NUM_CH);
  assign w_hs   = (r_state == ST_OFFER) && (|(r_valid & i_ch_ready));
  // Handshake wins over timeout in the last valid cycle.
  assign w_tmo  = (r_state == ST_OFFER) && !w_hs && (r_tmo == TMO_W'(TIMEOUT - 1));
  assign w_drop = ((r_state == ST_CAP) && !w_ok) || w_tmo;

  always_comb begin
    w_state_nxt = r_state;
    w_rd        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!i_fifo_empty) begin
          w_rd        = 1'b1;
          w_state_nxt = ST_RD;
        end
      end
      ST_RD:  w_state_nxt = ST_CAP;
      ST_CAP: w_state_nxt = w_ok ? ST_OFFER : ST_IDLE;
      ST_OFFER: begin
        if (w_hs) begin
          w_rd        = !i_fifo_empty;
          w_state_nxt = i_fifo_empty ? ST_IDLE : ST_RD;
        end else if (w_tmo) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tmo   <= '0;
      r_valid <= '0;
      r_desc  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_drop;
      if (r_state == ST_CAP) begin
        r_desc  <= w_in;
        r_valid <= w_ok ? ({{(NUM_CH-1){1'b0}}, 1'b1} << w_in.ch) : '0;
        r_tmo   <= '0;
      end else if (r_state == ST_OFFER) begin
        if (w_hs || w_tmo) r_valid <= '0;
        r_tmo <= r_tmo + 1'b1;
      end
    end
  end

  // The pop strobe is combinational so back-to-back offers stay 3 cycles apart.
  assign o_fifo_rd_en = w_rd && !i_rst;
  assign o_ch_valid   = r_valid;
  assign o_ch_desc    = r_desc;
  assign o_err_pulse  = r_err;

  dist_sat_cnt #(.W(CNT_W)) u_desc_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (w_hs),
    .o_cnt (o_desc_cnt)
  );

  dist_sat_cnt #(.W(CNT_W)) u_drop_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (w_drop),
    .o_cnt (o_drop_cnt)
  );

endmodule
